avr2wb_mbox_slave: RTL and testbench
====================================

# avr2wb_mbox_slave

Wishbone B3 classic slave mailbox that sits directly downstream of the AVR-to-Wishbone bridge's master port. The bridge's single 32-bit Wishbone transactions push words into a TX FIFO, which drains to a 32-bit valid/ready output stream, and pop words from an RX FIFO, which an input stream fills. FIFO status is exposed in registers. A maskable level interrupt, `irq_o`, feeds the bridge's `wb_irq` input.

## Interface
Parameters:
- `P_FIFO_DEPTH_LOG2`, default 3. Log2 of the depth of each FIFO; legal range 1..7, so depth is 2..128.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: Wishbone / system clock; all state on rising edge.
- `ireset` in 1: asynchronous active-low reset; released synchronously by the integrator.
- `adr_i` in 32: byte address; only [4:2] decoded; [31:5] and [1:0] ignored.
- `dat_i` in 32: write data.
- `dat_o` out 32: read data; valid only while `ack_o`=1; otherwise 0.
- `we_i` in 1: write enable.
- `sel_i` in 4: byte enables.
- `stb_i` in 1, `cyc_i` in 1: Wishbone strobe and cycle.
- `ack_o` out 1, `err_o` out 1: one-cycle response pulses.
- `rty_o` out 1: constant 0.
- `irq_o` out 1: registered level interrupt.
- `rx_data_i` in 32, `rx_valid_i` in 1, `rx_ready_o` out 1: RX stream input.
- `tx_data_o` out 32, `tx_valid_o` out 1, `tx_ready_i` in 1: TX stream output.

## Operation
- Response FSM has two states:
  - IDLE: samples `cyc_i & stb_i`; on a hit, performs the access and goes to RESP.
  - RESP: drives exactly one of `ack_o`/`err_o` high for one cycle, ignores `stb_i`, then returns to IDLE.
- Register map (by `adr_i[4:2]`):
  - 0 DATA.
    - Read: returns the RX head and pops it. If RX is empty: `err_o`, no pop, `dat_o`=0, set ERR.
    - Write: pushes the word to TX; bytes with `sel_i`=0 are written as 0x00. If TX is full: `err_o`, no push, set ERR.
  - 1 STATUS (read-only; writes are acked and ignored).
    - [7:0] RX level, [15:8] TX level.
    - [16] rx_empty, [17] rx_full, [18] tx_empty, [19] tx_full.
  - 2 IRQ_EN, bits [2:0], read/write.
    - bit 0 = RX non-empty, bit 1 = TX empty, bit 2 = ERR.
    - Written only when `sel_i[0]`=1; reset value 0.
  - 3 IRQ_STAT.
    - bit 0 = live !rx_empty; bit 1 = live tx_empty; bit 2 = sticky ERR.
    - Writing 1 to bit 2 with `sel_i[0]`=1 clears ERR; other bits are read-only.
  - 4..7: `err_o`, no side effects, ERR not set.
- Unused read bits return 0.
- FIFOs: depth 2^P. Read/write pointers are P bits and wrap naturally; level counters are P+1 bits. Full/empty flags derive from the registered levels.
- RX stream:
  - `rx_ready_o` = !rx_full.
  - A push occurs when `rx_valid_i & rx_ready_o`.
- TX stream:
  - `tx_valid_o` = !tx_empty; `tx_data_o` = TX head.
  - A pop occurs when `tx_valid_o & tx_ready_i`.
- `irq_o` <= |(IRQ_STAT[2:0] & IRQ_EN[2:0]), registered.

## Timing
- Request sampled at edge n. `ack_o`/`err_o` and `dat_o` are valid during cycle n+1. The earliest next acceptance is edge n+2.
- Minimum spacing for a master holding `stb_i` is 2 cycles per access.
- FIFO push/pop and register updates take effect at edge n; the STATUS value read reflects state before edge n.
- Simultaneous WB pop and stream push on RX: both occur and the level is unchanged. When RX is full, the stream push is still refused in that cycle, because `rx_ready_o` uses the registered level.
- Simultaneous WB push and stream pop on TX: both occur. When TX is full, the WB push is refused with `err_o` even if a stream pop happens in the same cycle.
- ERR set and a W1C clear in the same cycle cannot occur; DATA and IRQ_STAT are different addresses.
- `irq_o` lags its cause by 1 cycle.
- Reset values:
  - `ack_o`, `err_o`, `irq_o`, `dat_o`, `tx_valid_o`, `tx_data_o` = 0; `rx_ready_o` = 1.
  - FIFOs empty, IRQ_EN = 0, ERR = 0, FSM in IDLE.
- Reset asserted in RESP: the pending `ack_o`/`err_o` is dropped and both FIFOs are emptied.

## Test plan
- Reset, then read STATUS (0x4) -> `ack_o` 1 cycle later, `dat_o`=0x0005_0000 (rx_empty=1, tx_empty=1); `rx_ready_o`=1, `irq_o`=0.
- Write DATA with 0x1234_5678, `sel_i`=4'b0101, while `tx_ready_i`=0 -> ack; `tx_valid_o`=1, `tx_data_o`=0x0034_0078, STATUS[15:8]=1. Raise `tx_ready_i` -> word consumed, tx_empty=1.
- P=3: stream 8 RX words 0xA0..0xA7 -> `rx_ready_o`=0 after the 8th. Offer a 9th -> not accepted. Eight DATA reads -> 0xA0..0xA7 in order, each acked. A 9th read -> `err_o`, `dat_o`=0, IRQ_STAT=0x6.
- Set IRQ_EN=0x1, then push one RX word -> `irq_o`=1 one cycle after the push. Pop it -> `irq_o`=0 one cycle later. Set IRQ_EN=0x4, trigger a TX-full write error -> `irq_o`=1. Write IRQ_STAT=0x4 -> `irq_o`=0.
- Access address 0x14 (read and write) -> `err_o`, IRQ_STAT bit 2 unchanged. Back-to-back accesses with `stb_i` held -> responses exactly every 2 cycles.
- Assert `ireset` during the RESP cycle with 3 words in TX -> `ack_o` is not seen. After release: STATUS reads 0x0005_0000 and `tx_valid_o`=0.

Source files
------------

// File: rtl/avr2wb_mbox_slave.sv
// Wishbone classic slave mailbox: DATA writes feed a TX FIFO drained by a valid/ready
// stream, DATA reads pop an RX FIFO filled by a stream, plus status and a maskable level IRQ.
module avr2wb_mbox_slave #(
  parameter int P_FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk_i,
  input  logic        ireset,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic        ack_o,
  output logic        err_o,
  output logic        rty_o,
  output logic        irq_o,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        dbg_state_o
);
  localparam int P     = P_FIFO_DEPTH_LOG2;
  localparam int LW    = P + 1;
  localparam int DEPTH = 1 << P;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_e;

  // Bus protocol: a request is taken when cyc_i & stb_i are high in IDLE; the
  // response (ack_o or err_o, never both) is a one-cycle pulse in the next cycle.
  // Streams: a beat transfers on a rising edge where valid and ready are both high.
  state_e            state_q;
  logic              ack_q, err_q, irq_q, err_flag_q;
  logic [31:0]       dat_q;
  logic [2:0]        irq_en_q;
  logic [31:0]       rx_mem [DEPTH];
  logic [31:0]       tx_mem [DEPTH];
  logic [P-1:0]      rx_wr_q, rx_rd_q, tx_wr_q, tx_rd_q;
  logic [LW-1:0]     rx_lvl_q, tx_lvl_q;

  logic              rx_empty, rx_full, tx_empty, tx_full;
  logic              req, rx_push, tx_pop;
  logic              wb_rx_pop, wb_tx_push, wb_err, data_err;
  logic              irq_en_we, err_clr;
  logic [2:0]        reg_idx, irq_stat;
  logic [31:0]       rd_data, status_w, tx_wdata;
  logic              unused_adr;

  assign rx_empty = (rx_lvl_q == '0);
  assign rx_full  = (rx_lvl_q == FULL_LVL);
  assign tx_empty = (tx_lvl_q == '0);
  assign tx_full  = (tx_lvl_q == FULL_LVL);
  assign irq_stat = {err_flag_q, tx_empty, !rx_empty};
  assign status_w = {12'd0, tx_full, tx_empty, rx_full, rx_empty, 8'(tx_lvl_q), 8'(rx_lvl_q)};
  assign tx_wdata = {sel_i[3] ? dat_i[31:24] : 8'h00, sel_i[2] ? dat_i[23:16] : 8'h00,
                     sel_i[1] ? dat_i[15:8]  : 8'h00, sel_i[0] ? dat_i[7:0]   : 8'h00};

  assign req        = (state_q == S_IDLE) && cyc_i && stb_i;
  assign reg_idx    = adr_i[4:2];
  assign unused_adr = ^{adr_i[31:5], adr_i[1:0]};
  assign rx_push    = rx_valid_i && !rx_full;
  assign tx_pop     = !tx_empty && tx_ready_i;
  assign data_err   = wb_err && (reg_idx == 3'd0);
  assign irq_en_we  = req && we_i && (reg_idx == 3'd2) && sel_i[0];
  assign err_clr    = req && we_i && (reg_idx == 3'd3) && sel_i[0] && dat_i[2];

  always_comb begin
    wb_rx_pop  = 1'b0;
    wb_tx_push = 1'b0;
    wb_err     = 1'b0;
    rd_data    = '0;
    if (req) begin
      case (reg_idx)
        3'd0: begin
          if (we_i) begin
            if (tx_full) wb_err = 1'b1;
            else         wb_tx_push = 1'b1;
          end else begin
            if (rx_empty) wb_err = 1'b1;
            else begin
              wb_rx_pop = 1'b1;
              rd_data   = rx_mem[rx_rd_q];
            end
          end
        end
        3'd1:    rd_data = status_w;
        3'd2:    rd_data = {29'd0, irq_en_q};
        3'd3:    rd_data = {29'd0, irq_stat};
        default: wb_err = 1'b1;
      endcase
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and levels.
  always_ff @(posedge clk_i) begin
    if (rx_push)    rx_mem[rx_wr_q] <= rx_data_i;
    if (wb_tx_push) tx_mem[tx_wr_q] <= tx_wdata;
  end

  always_ff @(posedge clk_i or negedge ireset) begin
    if (!ireset) begin
      state_q    <= S_IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      irq_q      <= 1'b0;
      irq_en_q   <= '0;
      err_flag_q <= 1'b0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_lvl_q   <= '0;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_lvl_q   <= '0;
    end else begin
      irq_q <= |(irq_stat & irq_en_q);
      case (state_q)
        S_IDLE: begin
          if (req) begin
            state_q <= S_RESP;
            ack_q   <= !wb_err;
            err_q   <= wb_err;
            dat_q   <= (we_i || wb_err) ? 32'd0 : rd_data;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          dat_q   <= '0;
        end
      endcase
      if (irq_en_we) irq_en_q <= dat_i[2:0];
      if (data_err)     err_flag_q <= 1'b1;
      else if (err_clr) err_flag_q <= 1'b0;
      if (rx_push)    rx_wr_q <= rx_wr_q + 1'b1;
      if (wb_rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      if (wb_tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (tx_pop)     tx_rd_q <= tx_rd_q + 1'b1;
      rx_lvl_q <= rx_lvl_q + LW'(rx_push) - LW'(wb_rx_pop);
      tx_lvl_q <= tx_lvl_q + LW'(wb_tx_push) - LW'(tx_pop);
    end
  end

  assign dat_o       = dat_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rty_o       = 1'b0;
  assign irq_o       = irq_q;
  assign rx_ready_o  = !rx_full;
  assign tx_valid_o  = !tx_empty;
  assign tx_data_o   = tx_empty ? 32'd0 : tx_mem[tx_rd_q];
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_avr2wb_mbox_slave.sv
// Bench for avr2wb_mbox_slave: directed scenarios plus randomized traffic checked
// against a queue-based model of the mailbox.
module tb_avr2wb_mbox_slave;
  localparam int P     = 3;
  localparam int DEPTH = 1 << P;

  logic        clk_i = 1'b0;
  logic        ireset = 1'b0;
  logic [31:0] adr_i = '0, dat_i = '0, rx_data_i = '0;
  logic        we_i = 1'b0, stb_i = 1'b0, cyc_i = 1'b0, rx_valid_i = 1'b0, tx_ready_i = 1'b0;
  logic [3:0]  sel_i = '0;
  logic [31:0] dat_o, tx_data_o;
  logic        ack_o, err_o, rty_o, irq_o, rx_ready_o, tx_valid_o, dbg_state_o;

  int n_cmp  = 0;
  int n_fail = 0;

  // model state
  logic [31:0] rx_m[$];
  logic [31:0] tx_m[$];
  logic [2:0]  en_m;
  logic        err_m;

  avr2wb_mbox_slave #(.P_FIFO_DEPTH_LOG2(P)) dut (
    .clk_i(clk_i), .ireset(ireset), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_i), .ack_o(ack_o),
    .err_o(err_o), .rty_o(rty_o), .irq_o(irq_o), .rx_data_i(rx_data_i),
    .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .tx_data_o(tx_data_o),
    .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i), .dbg_state_o(dbg_state_o)
  );

  // clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mask_bytes(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = '0;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] status_m();
    return {12'd0, tx_m.size() == DEPTH, tx_m.size() == 0, rx_m.size() == DEPTH,
            rx_m.size() == 0, 8'(tx_m.size()), 8'(rx_m.size())};
  endfunction

  function automatic logic [2:0] irq_stat_m();
    return {err_m, tx_m.size() == 0, rx_m.size() != 0};
  endfunction

  task automatic model_reset();
    rx_m.delete();
    tx_m.delete();
    en_m  = '0;
    err_m = 1'b0;
  endtask

  // driver tasks
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, output logic ack, output logic err,
                         output logic [31:0] rdata);
    @(negedge clk_i);
    adr_i = adr; we_i = we; dat_i = dat; sel_i = sel; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    ack = ack_o; err = err_o; rdata = dat_o;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic model_access(input string tag, input logic [31:0] adr, input logic we,
                              input logic [31:0] dat, input logic [3:0] sel);
    logic        e_err = 1'b0;
    logic [31:0] e_dat = '0;
    logic        a, e;
    logic [31:0] r;
    case (adr[4:2])
      3'd0: begin
        if (we) begin
          if (tx_m.size() == DEPTH) begin e_err = 1'b1; err_m = 1'b1; end
          else tx_m.push_back(mask_bytes(dat, sel));
        end else begin
          if (rx_m.size() == 0) begin e_err = 1'b1; err_m = 1'b1; end
          else e_dat = rx_m.pop_front();
        end
      end
      3'd1: if (!we) e_dat = status_m();
      3'd2: begin
        if (we) begin if (sel[0]) en_m = dat[2:0]; end
        else e_dat = {29'd0, en_m};
      end
      3'd3: begin
        if (we) begin if (sel[0] && dat[2]) err_m = 1'b0; end
        else e_dat = {29'd0, irq_stat_m()};
      end
      default: e_err = 1'b1;
    endcase
    wb_xfer(adr, we, dat, sel, a, e, r);
    check({tag, "_ack"}, 32'(a), 32'(!e_err));
    check({tag, "_err"}, 32'(e), 32'(e_err));
    check({tag, "_dat"}, r, e_dat);
  endtask

  task automatic rx_push(input string tag, input logic [31:0] w);
    logic exp_rdy;
    @(negedge clk_i);
    exp_rdy = (rx_m.size() < DEPTH);
    check({tag, "_rx_ready"}, 32'(rx_ready_o), 32'(exp_rdy));
    rx_data_i = w; rx_valid_i = 1'b1;
    @(negedge clk_i);
    rx_valid_i = 1'b0;
    if (exp_rdy) rx_m.push_back(w);
  endtask

  task automatic tx_pop(input string tag);
    @(negedge clk_i);
    check({tag, "_tx_valid"}, 32'(tx_valid_o), 32'(tx_m.size() != 0));
    if (tx_m.size() != 0) check({tag, "_tx_data"}, tx_data_o, tx_m[0]);
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    tx_ready_i = 1'b0;
    if (tx_m.size() != 0) void'(tx_m.pop_front());
  endtask

  task automatic check_irq(input string tag);
    @(negedge clk_i);
    check(tag, 32'(irq_o), 32'(|(irq_stat_m() & en_m)));
  endtask

  initial begin
    logic        a, e;
    logic [31:0] r;
    logic [31:0] adr;
    // reset
    model_reset();
    ireset = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_tx_valid", 32'(tx_valid_o), 32'd0);
    check("rst_tx_data", tx_data_o, 32'd0);
    ireset = 1'b1;
    @(negedge clk_i);
    check("rst_rx_ready", 32'(rx_ready_o), 32'd1);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_rty", 32'(rty_o), 32'd0);
    model_access("status0", 32'h4, 1'b0, '0, 4'hf);

    // byte-masked TX write
    model_access("txw", 32'h0, 1'b1, 32'h1234_5678, 4'b0101);
    @(negedge clk_i);
    check("txw_valid", 32'(tx_valid_o), 32'd1);
    check("txw_data", tx_data_o, 32'h0034_0078);
    model_access("txw_status", 32'h4, 1'b0, '0, 4'hf);
    tx_pop("txw_pop");
    model_access("txw_status2", 32'h4, 1'b0, '0, 4'hf);

    // RX fill to full, overflow refused, drain, underflow error
    for (int i = 0; i < DEPTH; i++) rx_push("rxfill", 32'hA0 + 32'(i));
    @(negedge clk_i);
    check("rx_full_ready", 32'(rx_ready_o), 32'd0);
    rx_push("rx_ovf", 32'hDEAD_BEEF);
    model_access("rx_full_status", 32'h4, 1'b0, '0, 4'hf);
    for (int i = 0; i < DEPTH; i++) model_access("rxdrain", 32'h0, 1'b0, '0, 4'hf);
    model_access("rx_under", 32'h0, 1'b0, '0, 4'hf);
    model_access("irqstat_err", 32'hC, 1'b0, '0, 4'hf);
    model_access("err_clr", 32'hC, 1'b1, 32'h4, 4'h1);

    // interrupt: RX non-empty
    model_access("en_rx", 32'h8, 1'b1, 32'h1, 4'h1);
    rx_push("irq_push", 32'h5555_0001);
    check("irq_lag", 32'(irq_o), 32'd0);
    check_irq("irq_rx_set");
    model_access("irq_pop", 32'h0, 1'b0, '0, 4'hf);
    check_irq("irq_rx_clr");

    // interrupt: sticky ERR from TX overflow
    model_access("en_err", 32'h8, 1'b1, 32'h4, 4'h1);
    for (int i = 0; i <= DEPTH; i++) model_access("txfill", 32'h0, 1'b1, $urandom, 4'hf);
    check_irq("irq_err_set");
    model_access("irq_w1c", 32'hC, 1'b1, 32'h4, 4'h1);
    check_irq("irq_err_clr");
    while (tx_m.size() != 0) tx_pop("txdrain");

    // unmapped addresses
    model_access("bad_rd", 32'h14, 1'b0, '0, 4'hf);
    model_access("bad_wr", 32'h14, 1'b1, 32'hFFFF_FFFF, 4'hf);
    model_access("bad_irqstat", 32'hC, 1'b0, '0, 4'hf);

    // back-to-back accesses with stb held
    @(negedge clk_i);
    adr_i = 32'h4; we_i = 1'b0; sel_i = 4'hf; cyc_i = 1'b1; stb_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("b2b_ack", 32'(ack_o), 32'(i % 2 == 0));
    end
    cyc_i = 1'b0; stb_i = 1'b0;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0: rx_push("rnd_rx", $urandom);
        1: tx_pop("rnd_tx");
        default: begin
          adr = $urandom;
          if ($urandom_range(0, 2) != 0) adr[4:2] = 3'(($urandom_range(0, 1) == 0) ? 0 : $urandom_range(0, 3));
          model_access("rnd_wb", adr, 1'($urandom), $urandom, 4'($urandom));
        end
      endcase
      check_irq("rnd_irq");
    end

    // reset during the response cycle
    while (rx_m.size() != 0) model_access("pre_rst_rd", 32'h0, 1'b0, '0, 4'hf);
    while (tx_m.size() != 0) tx_pop("pre_rst_tx");
    for (int i = 0; i < 3; i++) model_access("pre_rst_tw", 32'h0, 1'b1, $urandom, 4'hf);
    @(negedge clk_i);
    adr_i = 32'h4; we_i = 1'b0; sel_i = 4'hf; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i);
    #1;
    ireset = 1'b0;
    cyc_i = 1'b0; stb_i = 1'b0;
    @(negedge clk_i);
    check("rst_resp_ack", 32'(ack_o), 32'd0);
    check("rst_resp_err", 32'(err_o), 32'd0);
    @(negedge clk_i);
    ireset = 1'b1;
    model_reset();
    @(negedge clk_i);
    check("post_rst_tx_valid", 32'(tx_valid_o), 32'd0);
    model_access("post_rst_status", 32'h4, 1'b0, '0, 4'hf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
